// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: widths, opcodes, branch funct3 codes,
// branch-unit FSM states and immediate field extraction helpers.
package riscv_pkg;

    localparam int XLEN           = 32;
    localparam int REG_SELECT_LEN = 5;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [2:0] {
        F3_EQ  = 3'b000,
        F3_NE  = 3'b001,
        F3_LT  = 3'b100,
        F3_GE  = 3'b101,
        F3_LTU = 3'b110,
        F3_GEU = 3'b111
    } branch_funct3_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_DONE = 2'd3
    } bu_state_t;

    // Raw immediates; callers sign-extend to their datapath width from the MSB.
    function automatic logic [12:0] imm_b(input logic [31:0] instr);
        return {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    endfunction

    function automatic logic [20:0] imm_j(input logic [31:0] instr);
        return {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    endfunction

    function automatic logic [11:0] imm_i(input logic [31:0] instr);
        return instr[31:20];
    endfunction

endpackage

// File: rtl/branch_compare.sv
// Branch condition evaluation: resolves taken for a branch funct3 and
// flags funct3 codes that are not defined for branches.
module branch_compare #(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [2:0]      funct3,
    output logic            taken,
    output logic            valid_funct3
);
    import riscv_pkg::*;

    // Compare operands according to the branch condition code.
    always_comb begin
        taken        = 1'b0;
        valid_funct3 = 1'b1;
        case (funct3)
            F3_EQ:   taken = (a == b);
            F3_NE:   taken = (a != b);
            F3_LT:   taken = ($signed(a) <  $signed(b));
            F3_GE:   taken = ($signed(a) >= $signed(b));
            F3_LTU:  taken = (a <  b);
            F3_GEU:  taken = (a >= b);
            default: valid_funct3 = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_unit.sv
// Multi-cycle branch/jump resolution unit for the RV32I core.
// Optional feature macro: BRANCH_MISALIGN_TRAP_EN (trap on taken targets
// that are not 4-byte aligned instead of redirecting).
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | ready for a new instruction; rs selects latched on accept
// ST_READ | register file data captured
// ST_EXEC | decode/compare/targets computed, result outputs registered
// ST_DONE | result presented with out_valid until out_ready
module branch_unit #(
    parameter int XLEN           = riscv_pkg::XLEN,
    parameter int REG_SELECT_LEN = riscv_pkg::REG_SELECT_LEN
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [XLEN-1:0]           instruction,
    input  logic [XLEN-1:0]           program_counter,
    output logic [REG_SELECT_LEN-1:0] register_1,
    output logic [REG_SELECT_LEN-1:0] register_2,
    input  logic [XLEN-1:0]           register_data_1,
    input  logic [XLEN-1:0]           register_data_2,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      load_new_program_counter,
    output logic [XLEN-1:0]           new_program_counter,
    output logic                      link_write,
    output logic [REG_SELECT_LEN-1:0] link_register,
    output logic [XLEN-1:0]           link_data,
    output logic                      illegal,
    output logic                      misaligned
);
    import riscv_pkg::*;

    bu_state_t                 state, state_next;
    logic [XLEN-1:0]           instr_q, pc_q, rs1_q, rs2_q;

    logic [6:0]                opcode;
    logic [2:0]                funct3;
    logic [REG_SELECT_LEN-1:0] rd;
    logic [12:0]               raw_b;
    logic [20:0]               raw_j;
    logic [11:0]               raw_i;
    logic [XLEN-1:0]           off_b, off_j, off_i;
    logic [XLEN-1:0]           pc_plus4, target, npc_d;
    logic                      cmp_taken, cmp_valid;
    logic                      taken, legal, is_jump, redirect, link_en, mis_d;
    logic [REG_SELECT_LEN-1:0] link_reg_d;

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);

    assign opcode = instr_q[6:0];
    assign funct3 = instr_q[14:12];
    assign rd     = REG_SELECT_LEN'(instr_q[11:7]);
    assign raw_b  = imm_b(instr_q[31:0]);
    assign raw_j  = imm_j(instr_q[31:0]);
    assign raw_i  = imm_i(instr_q[31:0]);
    assign off_b  = {{(XLEN-13){raw_b[12]}}, raw_b};
    assign off_j  = {{(XLEN-21){raw_j[20]}}, raw_j};
    assign off_i  = {{(XLEN-12){raw_i[11]}}, raw_i};

    branch_compare #(.XLEN(XLEN)) u_compare (
        .a            (rs1_q),
        .b            (rs2_q),
        .funct3       (funct3),
        .taken        (cmp_taken),
        .valid_funct3 (cmp_valid)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Next-state sequencing; a result is only released on out_ready.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (in_valid) state_next = ST_READ;
            ST_READ: state_next = ST_EXEC;
            ST_EXEC: state_next = ST_DONE;
            ST_DONE: if (out_ready) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Decode, target arithmetic and result selection for the instruction held in EXEC.
    always_comb begin
        pc_plus4 = pc_q + XLEN'(4);
        target   = '0;
        taken    = 1'b0;
        legal    = 1'b0;
        is_jump  = 1'b0;
        case (opcode)
            OPC_BRANCH: begin
                target = pc_q + off_b;
                taken  = cmp_taken;
                legal  = cmp_valid;
            end
            OPC_JAL: begin
                target  = pc_q + off_j;
                taken   = 1'b1;
                legal   = 1'b1;
                is_jump = 1'b1;
            end
            OPC_JALR: begin
                target  = (rs1_q + off_i) & {{(XLEN-1){1'b1}}, 1'b0};
                taken   = 1'b1;
                legal   = (funct3 == 3'b000);
                is_jump = 1'b1;
            end
            default: ;
        endcase
        redirect   = legal && taken;
        link_en    = legal && is_jump && (rd != '0);
        link_reg_d = (legal && is_jump) ? rd : '0;
        npc_d      = redirect ? target : pc_plus4;
        mis_d      = 1'b0;
`ifdef BRANCH_MISALIGN_TRAP_EN
        // A misaligned taken target becomes a trap: the target is still reported
        // on new_program_counter, but fetch is not redirected and no link is written.
        if (redirect && (target[1:0] != 2'b00)) begin
            mis_d    = 1'b1;
            redirect = 1'b0;
            link_en  = 1'b0;
        end
`endif
    end

    // Datapath registers: operand capture on accept/READ, result capture in EXEC.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q                  <= '0;
            pc_q                     <= '0;
            rs1_q                    <= '0;
            rs2_q                    <= '0;
            register_1               <= '0;
            register_2               <= '0;
            load_new_program_counter <= 1'b0;
            new_program_counter      <= '0;
            link_write               <= 1'b0;
            link_register            <= '0;
            link_data                <= '0;
            illegal                  <= 1'b0;
            misaligned               <= 1'b0;
        end else begin
            if (state == ST_IDLE && in_valid) begin
                instr_q    <= instruction;
                pc_q       <= program_counter;
                register_1 <= REG_SELECT_LEN'(instruction[19:15]);
                register_2 <= REG_SELECT_LEN'(instruction[24:20]);
            end
            if (state == ST_READ) begin
                rs1_q <= register_data_1;
                rs2_q <= register_data_2;
            end
            if (state == ST_EXEC) begin
                load_new_program_counter <= redirect;
                new_program_counter      <= npc_d;
                link_write               <= link_en;
                link_register            <= link_reg_d;
                link_data                <= pc_plus4;
                illegal                  <= !legal;
                misaligned               <= mis_d;
            end
        end
    end

endmodule
